// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Constants shared by the UART transmitter and receiver.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Last baud counter value per bit: 50 MHz system clock, 9600 baud
    localparam int BAUD_END_9600 = 5207;
    // Short bit time used when simulating the link
    localparam int BAUD_END_SIM  = 56;
    // Index of the last data bit; bit 0 is the start bit
    localparam int BIT_END       = 8;
    // Width of one character
    localparam int DATA_W        = 8;

    // Baud counter value at which a bit is sampled (middle of the bit)
    function automatic int baud_mid(input int baud_end);
        return baud_end / 2 - 1;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sync
//  Description : Three-flop synchroniser for the asynchronous serial line
//                plus a falling-edge detector on the synchronised copy.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_sync (
    input  logic sclk,
    input  logic s_rst,
    input  logic din,
    output logic dout,
    output logic fall
);

    logic r_rx1;
    logic r_rx2;
    logic r_rx3;

    // Resynchronise the line; reset to the idle (high) level so that a
    // reset never looks like a start edge
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            r_rx1 <= 1'b1;
            r_rx2 <= 1'b1;
            r_rx3 <= 1'b1;
        end else begin
            r_rx1 <= din;
            r_rx2 <= r_rx1;
            r_rx3 <= r_rx2;
        end
    end

    assign dout = r_rx2;
    assign fall = r_rx3 & ~r_rx2;

endmodule : uart_rx_sync
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : RS-232 8N1 receiver, LSB first. Produces a parallel byte
//                and a one-cycle valid strobe. One bit lasts BAUD_END+1
//                sclk cycles; every bit is sampled once near its middle.
//                Optional macro UART_RX_FRAME_CHK_EN adds a stop-bit sample
//                and a one-cycle frame_err pulse on a bad stop bit.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_END = BAUD_END_9600,
    parameter int BAUD_M   = baud_mid(BAUD_END)
) (
    input  logic              sclk,
    input  logic              s_rst,
    input  logic              rs232_rx,
    output logic [DATA_W-1:0] po_data,
    output logic              po_flag,
    output logic              frame_err
);

    localparam int c_CNT_W = $clog2(BAUD_END + 1);
    localparam int c_BIT_W = 4;

    localparam logic [c_CNT_W-1:0] c_BAUD_END = c_CNT_W'(BAUD_END);
    localparam logic [c_CNT_W-1:0] c_BAUD_M   = c_CNT_W'(BAUD_M);
    localparam logic [c_BIT_W-1:0] c_BIT_END  = c_BIT_W'(BIT_END);

`ifdef UART_RX_FRAME_CHK_EN
    // The frame ends on the stop-bit sample; the byte is complete in the
    // shift register by then, so all DATA_W bits are kept.
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(BIT_END + 1);
    localparam int                 c_SHIFT_W  = DATA_W;
`else
    // The frame ends on the last data sample; the byte is taken straight
    // from the shift input, so the register never needs the oldest bit.
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(BIT_END);
    localparam int                 c_SHIFT_W  = DATA_W - 1;
`endif

    logic                 w_rx;
    logic                 w_fall;
    logic                 r_rx_flag;
    logic [c_CNT_W-1:0]   r_baud_cnt;
    logic                 r_bit_flag;
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic [c_SHIFT_W-1:0] r_shift;
    logic [DATA_W-1:0]    r_po_data;
    logic                 r_po_flag;

    logic                 w_sample;
    logic                 w_glitch;
    logic                 w_data_bit;
    logic                 w_end;
    logic                 w_good;
    logic [DATA_W-1:0]    w_shift_next;
    logic [DATA_W-1:0]    w_out_data;

    uart_rx_sync u_sync (
        .sclk  (sclk),
        .s_rst (s_rst),
        .din   (rs232_rx),
        .dout  (w_rx),
        .fall  (w_fall)
    );

    assign w_sample   = r_rx_flag & r_bit_flag;
    // A start bit that reads high at mid-bit was only a glitch
    assign w_glitch   = w_sample & (r_bit_cnt == '0) & w_rx;
    assign w_data_bit = w_sample & (r_bit_cnt != '0) & (r_bit_cnt <= c_BIT_END);
    assign w_end      = w_sample & (r_bit_cnt == c_LAST_BIT);

    // New bit enters at the top; the first bit received ends up as the LSB
    assign w_shift_next = {w_rx, r_shift[c_SHIFT_W-1 -: DATA_W-1]};

`ifdef UART_RX_FRAME_CHK_EN
    logic w_bad;
    logic r_frame_err;

    assign w_good     = w_end & w_rx;
    assign w_bad      = w_end & ~w_rx;
    assign w_out_data = r_shift;

    // Flag a stop bit that reads low
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_bad;
        end
    end

    assign frame_err = r_frame_err;
`else
    assign w_good     = w_end;
    assign w_out_data = w_shift_next;
    assign frame_err  = 1'b0;
`endif

    // Frame-in-progress flag: armed by a start edge, dropped on a glitch or
    // on the final sample of the frame
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            r_rx_flag <= 1'b0;
        end else if (!r_rx_flag) begin
            if (w_fall) begin
                r_rx_flag <= 1'b1;
            end
        end else if (w_glitch || w_end) begin
            r_rx_flag <= 1'b0;
        end
    end

    // Bit-period counter, parked at zero between frames
    always_ff @(posedge sclk) begin
        if (s_rst || !r_rx_flag) begin
            r_baud_cnt <= '0;
        end else if (r_baud_cnt == c_BAUD_END) begin
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
        end
    end

    // Mid-bit sample strobe, one cycle after the counter hits its midpoint
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            r_bit_flag <= 1'b0;
        end else begin
            r_bit_flag <= r_rx_flag && (r_baud_cnt == c_BAUD_M);
        end
    end

    // Index of the bit being sampled; cleared together with the frame flag
    always_ff @(posedge sclk) begin
        if (s_rst || !r_rx_flag || w_glitch || w_end) begin
            r_bit_cnt <= '0;
        end else if (w_sample) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    // Collect data bits LSB first
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            r_shift <= '0;
        end else if (w_data_bit) begin
            r_shift <= w_shift_next[DATA_W-1 -: c_SHIFT_W];
        end
    end

    // Publish a completed byte with a one-cycle strobe; hold it otherwise
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            r_po_data <= '0;
            r_po_flag <= 1'b0;
        end else begin
            r_po_flag <= w_good;
            if (w_good) begin
                r_po_data <= w_out_data;
            end
        end
    end

    assign po_data = r_po_data;
    assign po_flag = r_po_flag;

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. A serial driver plays the
//                transmitter; expected bytes are queued when a frame is
//                driven and compared when po_flag is seen.
//                Define UART_RX_FRAME_CHK_EN to exercise the stop-bit check.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;
    import uart_pkg::*;

    localparam int c_BIT_CYC = BAUD_END_SIM + 1;
`ifdef UART_RX_FRAME_CHK_EN
    // line fall -> po_flag: 2 sync + 1 arm + 9 bits + mid point + 2
    localparam int c_LAT     = 3 + 9 * c_BIT_CYC + (BAUD_END_SIM / 2 - 1) + 2;
    localparam int c_EXP_FE  = 1;
`else
    localparam int c_LAT     = 3 + 8 * c_BIT_CYC + (BAUD_END_SIM / 2 - 1) + 2;
    localparam int c_EXP_FE  = 0;
`endif

    logic       sclk     = 1'b0;
    logic       s_rst    = 1'b1;
    logic       rs232_rx = 1'b1;
    logic [7:0] po_data;
    logic       po_flag;
    logic       frame_err;

    uart_rx #(
        .BAUD_END (BAUD_END_SIM)
    ) dut (
        .sclk      (sclk),
        .s_rst     (s_rst),
        .rs232_rx  (rs232_rx),
        .po_data   (po_data),
        .po_flag   (po_flag),
        .frame_err (frame_err)
    );

    always #5 sclk = ~sclk;

    int unsigned cyc = 0;
    always @(posedge sclk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  exp_q[$];
    int unsigned t_start       = 0;
    int unsigned last_flag_cyc = 0;
    int unsigned flag_gap      = 0;
    int          n_frame_err   = 0;
    logic        prev_flag     = 1'b0;
    bit          lat_armed     = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Output monitor / scoreboard
    always @(negedge sclk) begin
        if (po_flag) begin
            check_eq("flag_width", {31'd0, prev_flag}, 32'd0);
            check_eq("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                check_eq("po_data", {24'd0, po_data}, {24'd0, exp_q.pop_front()});
            end
            if (lat_armed) begin
                check_eq("latency", cyc - t_start, c_LAT);
                lat_armed = 1'b0;
            end
            flag_gap      = cyc - last_flag_cyc;
            last_flag_cyc = cyc;
        end
        if (frame_err) n_frame_err++;
        prev_flag = po_flag;
    end

    task automatic drive_bit(input logic b);
        rs232_rx = b;
        repeat (c_BIT_CYC) @(posedge sclk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop, input bit expect_out);
        if (expect_out) exp_q.push_back(d);
        rs232_rx = 1'b0;
        t_start  = cyc;
        repeat (c_BIT_CYC) @(posedge sclk);
        #1;
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
        rs232_rx = 1'b1;
    endtask

    task automatic idle(input int n);
        rs232_rx = 1'b1;
        repeat (n) @(posedge sclk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge sclk);
        #1;
        check_eq("rst_po_data",   {24'd0, po_data}, 32'd0);
        check_eq("rst_po_flag",   {31'd0, po_flag}, 32'd0);
        check_eq("rst_frame_err", {31'd0, frame_err}, 32'd0);
        s_rst = 1'b0;
        idle(20);

        // single frame with latency check
        lat_armed = 1'b1;
        send_byte(8'h55, 1'b1, 1'b1);
        idle(100);
        check_eq("t1_pending", exp_q.size(), 32'd0);

        // back-to-back frames
        send_byte(8'hA3, 1'b1, 1'b1);
        send_byte(8'h0F, 1'b1, 1'b1);
        idle(100);
        check_eq("b2b_gap", flag_gap, 10 * c_BIT_CYC);
        check_eq("b2b_last", {24'd0, po_data}, 32'h0F);

        // short low glitch on an idle line
        rs232_rx = 1'b0;
        repeat (10) @(posedge sclk);
        #1;
        idle(200);
        check_eq("glitch_hold", {24'd0, po_data}, 32'h0F);
        send_byte(8'h3C, 1'b1, 1'b1);
        idle(100);

        // reset in the middle of 0xFF
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        s_rst = 1'b1;
        @(posedge sclk);
        #1;
        s_rst = 1'b0;
        idle(700);
        check_eq("rst_mid_data", {24'd0, po_data}, 32'd0);
        send_byte(8'h81, 1'b1, 1'b1);
        idle(100);

`ifdef UART_RX_FRAME_CHK_EN
        // bad stop bit, then a good frame
        send_byte(8'h7E, 1'b0, 1'b0);
        idle(100);
        check_eq("fe_count", n_frame_err, 32'd1);
        check_eq("fe_data_hold", {24'd0, po_data}, 32'h81);
        send_byte(8'h7E, 1'b1, 1'b1);
        idle(100);
        check_eq("fe_good_data", {24'd0, po_data}, 32'h7E);
`endif

        // loopback-style byte sweep, back-to-back
        for (int i = 0; i < 256; i += 4) send_byte(i[7:0], 1'b1, 1'b1);
        send_byte(8'hFF, 1'b1, 1'b1);
        idle(200);

        check_eq("sb_drain", exp_q.size(), 32'd0);
        check_eq("frame_err_total", n_frame_err, c_EXP_FE);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        repeat (200000) @(posedge sclk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_uart_rx
`default_nettype wire
